// File: rtl/round_pipe.sv
// Two-stage significand rounder (RNE/RTZ/RDN/RUP/RMM) with a valid/ready handshake.
// Define ROUND_STATS_EN to add the saturating inexact_cnt/ovf_cnt delivery counters.
module round_pipe #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*NSIG+1:0] pSig,
    input  logic              sign,
    input  logic [2:0]        rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NSIG-1:0]   roundedSig,
    output logic              overFlow,
    output logic              inexact
`ifdef ROUND_STATS_EN
    ,
    output logic [15:0]       inexact_cnt,
    output logic [15:0]       ovf_cnt
`endif
);

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rndMode_t;

    if (NSIG < 2 || NEXP < 1) begin : gBadParams
        $error("round_pipe: NSIG must be at least 2 and NEXP at least 1");
    end

    logic [NSIG-1:0] keepIn;
    logic            lsbBit;
    logic            guardBit;
    logic            roundBit;
    logic            stickyBit;
    logic            incIn;
    logic            inexactIn;
    logic            unusedMsb;

    logic            s1Valid;
    logic [NSIG-1:0] s1Keep;
    logic            s1Inc;
    logic            s1Inexact;

    logic            s2Adv;
    logic            accept;
    logic [NSIG:0]   sum;

    // The top product bit is already normalised away upstream.
    assign unusedMsb = pSig[2*NSIG+1];

    always_comb begin
        keepIn    = pSig[2*NSIG:NSIG+1];
        lsbBit    = pSig[NSIG+1];
        guardBit  = pSig[NSIG];
        roundBit  = pSig[NSIG-1];
        stickyBit = |pSig[NSIG-2:0];
        inexactIn = guardBit | roundBit | stickyBit;
        case (rmode)
            RTZ:     incIn = 1'b0;
            RDN:     incIn = sign & inexactIn;
            RUP:     incIn = ~sign & inexactIn;
            RMM:     incIn = guardBit;
            default: incIn = guardBit & (roundBit | stickyBit | lsbBit);
        endcase
    end

    always_comb begin
        s2Adv    = ~out_valid | out_ready;
        in_ready = ~s1Valid | s2Adv;
        accept   = in_valid & in_ready;
        sum      = {1'b0, s1Keep} + {{NSIG{1'b0}}, s1Inc};
    end

    // S1 refills on the same edge its beat moves on, so streaming never bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid   <= 1'b0;
            s1Keep    <= '0;
            s1Inc     <= 1'b0;
            s1Inexact <= 1'b0;
        end else if (accept) begin
            s1Valid   <= 1'b1;
            s1Keep    <= keepIn;
            s1Inc     <= incIn;
            s1Inexact <= inexactIn;
        end else if (s2Adv) begin
            s1Valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            roundedSig <= '0;
            overFlow   <= 1'b0;
            inexact    <= 1'b0;
        end else if (s2Adv) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                {overFlow, roundedSig} <= sum;
                inexact                <= s1Inexact;
            end
        end
    end

`ifdef ROUND_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inexact_cnt <= '0;
            ovf_cnt     <= '0;
        end else if (out_valid && out_ready) begin
            if (inexact && inexact_cnt != '1) inexact_cnt <= inexact_cnt + 16'd1;
            if (overFlow && ovf_cnt != '1)    ovf_cnt     <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_round_pipe.sv
// Bench for round_pipe: directed vector table, stall/reset sequences and a randomized
// stream scored against an arithmetic rounding model.
module tb_round_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pSig;
    logic        sign;
    logic [2:0]  rmode;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  roundedSig;
    logic        overFlow;
    logic        inexact;
`ifdef ROUND_STATS_EN
    logic [15:0] inexact_cnt;
    logic [15:0] ovf_cnt;
`endif

    round_pipe #(.NEXP(8), .NSIG(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pSig       (pSig),
        .sign       (sign),
        .rmode      (rmode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .roundedSig (roundedSig),
        .overFlow   (overFlow),
        .inexact    (inexact)
`ifdef ROUND_STATS_EN
        ,
        .inexact_cnt(inexact_cnt),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] sig;
        logic       ovf;
        logic       inex;
    } expT;

    typedef struct {
        logic [15:0] p;
        logic        s;
        logic [2:0]  m;
        logic [6:0]  sig;
        logic        ovf;
        logic        inex;
    } vecT;

    int  total = 0;
    int  bad = 0;
    int  popCount = 0;
    int  expInexCnt = 0;
    int  expOvfCnt = 0;
    expT q[$];
    logic       prevStall = 1'b0;
    logic [8:0] prevOut = '0;
    vecT vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Rounding from the value of the discarded fraction relative to one half.
    function automatic expT refModel(input logic [15:0] p, input logic s, input logic [2:0] m);
        int keep;
        int rest;
        int up;
        int tot;
        expT r;
        keep = (int'(p) / 256) % 128;
        rest = int'(p) % 256;
        case (m)
            3'd1:    up = 0;
            3'd2:    up = (s && rest != 0) ? 1 : 0;
            3'd3:    up = (!s && rest != 0) ? 1 : 0;
            3'd4:    up = (rest >= 128) ? 1 : 0;
            default: up = (rest > 128 || (rest == 128 && keep % 2 == 1)) ? 1 : 0;
        endcase
        tot    = keep + up;
        r.sig  = 7'(tot % 128);
        r.ovf  = (tot >= 128);
        r.inex = (rest != 0);
        return r;
    endfunction

    always @(negedge clk) begin
        expT e;
        if (rst) begin
            q.delete();
            prevStall  = 1'b0;
            expInexCnt = 0;
            expOvfCnt  = 0;
        end else begin
            if (prevStall) begin
                check("stallValid", 32'(out_valid), 32'd1);
                check("stallData", 32'({roundedSig, overFlow, inexact}), 32'(prevOut));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpectedBeat actual=%h required=none", roundedSig);
                end else begin
                    e = q.pop_front();
                    check("sbSig", 32'(roundedSig), 32'(e.sig));
                    check("sbOvf", 32'(overFlow), 32'(e.ovf));
                    check("sbInexact", 32'(inexact), 32'(e.inex));
                    popCount++;
                    if (e.inex) expInexCnt++;
                    if (e.ovf)  expOvfCnt++;
                end
            end
            if (in_valid && in_ready) q.push_back(refModel(pSig, sign, rmode));
            prevStall = out_valid && !out_ready;
            prevOut   = {roundedSig, overFlow, inexact};
        end
    end

    task automatic sendBeat(input logic [15:0] p, input logic s, input logic [2:0] m);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        pSig     = p;
        sign     = s;
        rmode    = m;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check("acceptTimeout", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drainEmpty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string name);
        check({name, "Valid"}, 32'(out_valid), 32'd0);
        check({name, "Ready"}, 32'(in_ready), 32'd1);
        check({name, "Data"}, 32'({roundedSig, overFlow, inexact}), 32'd0);
`ifdef ROUND_STATS_EN
        check({name, "Cnt"}, 32'({inexact_cnt, ovf_cnt}), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        int startPops;
        logic [15:0] rp;

        vecs[0]  = '{16'h5580, 1'b0, 3'd0, 7'h56, 1'b0, 1'b1};
        vecs[1]  = '{16'h5580, 1'b0, 3'd1, 7'h55, 1'b0, 1'b1};
        vecs[2]  = '{16'h7FC0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1};
        vecs[3]  = '{16'h1001, 1'b1, 3'd2, 7'h11, 1'b0, 1'b1};
        vecs[4]  = '{16'h1001, 1'b0, 3'd2, 7'h10, 1'b0, 1'b1};
        vecs[5]  = '{16'h1001, 1'b0, 3'd3, 7'h11, 1'b0, 1'b1};
        vecs[6]  = '{16'h1001, 1'b1, 3'd3, 7'h10, 1'b0, 1'b1};
        vecs[7]  = '{16'h1000, 1'b0, 3'd0, 7'h10, 1'b0, 1'b0};
        vecs[8]  = '{16'h1000, 1'b1, 3'd2, 7'h10, 1'b0, 1'b0};
        vecs[9]  = '{16'h1000, 1'b0, 3'd3, 7'h10, 1'b0, 1'b0};
        vecs[10] = '{16'h1000, 1'b1, 3'd4, 7'h10, 1'b0, 1'b0};
        vecs[11] = '{16'h5480, 1'b0, 3'd0, 7'h54, 1'b0, 1'b1};
        vecs[12] = '{16'h5480, 1'b0, 3'd4, 7'h55, 1'b0, 1'b1};
        vecs[13] = '{16'h5440, 1'b0, 3'd4, 7'h54, 1'b0, 1'b1};
        vecs[14] = '{16'h5481, 1'b0, 3'd0, 7'h55, 1'b0, 1'b1};
        vecs[15] = '{16'h2B00, 1'b0, 3'd0, 7'h2B, 1'b0, 1'b0};
        vecs[16] = '{16'hFF80, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1};
        vecs[17] = '{16'h7F80, 1'b0, 3'd6, 7'h00, 1'b1, 1'b1};
        vecs[18] = '{16'h7F01, 1'b1, 3'd2, 7'h00, 1'b1, 1'b1};
        vecs[19] = '{16'h7F01, 1'b0, 3'd1, 7'h7F, 1'b0, 1'b1};
        vecs[20] = '{16'h1040, 1'b0, 3'd0, 7'h10, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pSig      = '0;
        sign      = 1'b0;
        rmode     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset");

        // Directed vectors, each checked exactly two cycles after acceptance.
        for (int i = 0; i < 21; i++) begin
            sendBeat(vecs[i].p, vecs[i].s, vecs[i].m);
            @(posedge clk);
            #1;
            check("vecValid", 32'(out_valid), 32'd1);
            check("vecSig", 32'(roundedSig), 32'(vecs[i].sig));
            check("vecOvf", 32'(overFlow), 32'(vecs[i].ovf));
            check("vecInexact", 32'(inexact), 32'(vecs[i].inex));
        end
        drain();

        // Six back-to-back beats with a four-cycle output stall mid-stream.
        startPops = popCount;
        fork
            begin
                for (int i = 0; i < 6; i++) sendBeat(16'h5480 + 16'(i * 16'h0141), 1'(i), 3'(i % 5));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                check("bpInReady", 32'(in_ready), 32'd0);
                check("bpOutValid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bpBeatCount", 32'(popCount - startPops), 32'd6);

        // Reset with both stages full and the output stalled.
        out_ready = 1'b0;
        sendBeat(16'h5580, 1'b0, 3'd0);
        sendBeat(16'h7FC0, 1'b0, 3'd0);
        @(negedge clk);
        check("fullInReady", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("midReset");
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("noStale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

`ifdef ROUND_STATS_EN
        fork
            begin
                sendBeat(16'h5580, 1'b0, 3'd0);
                sendBeat(16'h7FC0, 1'b0, 3'd0);
                sendBeat(16'h1001, 1'b0, 3'd1);
                sendBeat(16'h1000, 1'b0, 3'd0);
                sendBeat(16'h2B00, 1'b1, 3'd2);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("statsInexact", 32'(inexact_cnt), 32'd3);
        check("statsOvf", 32'(ovf_cnt), 32'd1);
`endif

        // Randomized stream with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    rp = 16'($urandom);
                    case ($urandom_range(0, 4))
                        0: rp[7:0] = 8'h80;
                        1: rp[7:0] = 8'h00;
                        2: rp[14:8] = 7'h7F;
                        default: ;
                    endcase
                    sendBeat(rp, 1'($urandom), 3'($urandom_range(0, 7)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

`ifdef ROUND_STATS_EN
        check("finalInexactCnt", 32'(inexact_cnt), 32'(expInexCnt));
        check("finalOvfCnt", 32'(ovf_cnt), 32'(expOvfCnt));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
